pim_trace: RTL and testbench

Parametrised, event-qualified trace buffer for one MPMC/NPI PIM port. It samples PIM address, write and read handshakes on the PIM clock and stores one compressed record per qualifying event in an on-chip circular buffer. Capture stops after a programmable address/RNW trigger followed by a post-trigger count. The buffer is read back through a simple RAM-style port by a register/debug master, or held for ChipScope.

---
 rtl/pim_trace_pkg.sv | 51 +++++
 rtl/pim_trace_ram.sv | 40 ++++
 rtl/pim_trace.sv | 180 ++++++++++++++++++
 tb/tb_pim_trace.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pim_trace_pkg.sv
// ============================================================================
// pim_trace_pkg : shared constants, state encoding and record layout helpers
// Rev 1.0 | optional timestamp field enabled by macro PIM_TRACE_TS_EN
// ============================================================================
`default_nettype none

package pim_trace_pkg;

`ifdef PIM_TRACE_TS_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  localparam logic [1:0] EVT_ADDR = 2'b01;
  localparam logic [1:0] EVT_WR   = 2'b10;
  localparam logic [1:0] EVT_RD   = 2'b11;

  localparam int INFO_W = 8;
  localparam int EVT_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_POST  = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  function automatic int ts_w(input int tsw);
    return TS_EN ? tsw : 0;
  endfunction

  function automatic int rec_w(input int dw, input int tsw);
    return ts_w(tsw) + EVT_W + INFO_W + dw;
  endfunction

  function automatic int info_lsb(input int dw);
    return dw;
  endfunction

  function automatic int evt_lsb(input int dw);
    return dw + INFO_W;
  endfunction

  function automatic int ts_lsb(input int dw);
    return dw + INFO_W + EVT_W;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pim_trace_ram.sv
// ============================================================================
// pim_trace_ram : simple dual-port record RAM, registered read-first port
// Rev 1.0
// ============================================================================
`default_nettype none

module pim_trace_ram #(
  parameter int WIDTH  = 42,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Output register only is reset so the array still maps onto block RAM.
  always_ff @(posedge clk) begin
    if (rst)       r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/pim_trace.sv
// ============================================================================
// pim_trace : event-qualified PIM trace buffer with address/RNW trigger
// Rev 1.0 | define PIM_TRACE_TS_EN to prepend a timestamp to every record
// ============================================================================
`default_nettype none

module pim_trace
  import pim_trace_pkg::*;
#(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_DEPTH_LOG2 = 9,
  parameter int C_TS_WIDTH   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               PIM_Addr,
  input  logic                      PIM_AddrReq,
  input  logic                      PIM_AddrAck,
  input  logic                      PIM_RNW,
  input  logic [3:0]                PIM_Size,
  input  logic [C_DATA_WIDTH-1:0]   PIM_WrFIFO_Data,
  input  logic [C_DATA_WIDTH/8-1:0] PIM_WrFIFO_BE,
  input  logic                      PIM_WrFIFO_Push,
  input  logic [C_DATA_WIDTH-1:0]   PIM_RdFIFO_Data,
  input  logic                      PIM_RdFIFO_Pop,
  input  logic                      Cfg_Arm,
  input  logic                      Cfg_Force_Trig,
  input  logic [31:0]               Cfg_Addr_Match,
  input  logic [31:0]               Cfg_Addr_Mask,
  input  logic                      Cfg_Rnw_Care,
  input  logic                      Cfg_Rnw_Val,
  input  logic [C_DEPTH_LOG2-1:0]   Cfg_Post_Cnt,
  input  logic                      Rd_En,
  input  logic [C_DEPTH_LOG2-1:0]   Rd_Addr,
  output logic [rec_w(C_DATA_WIDTH, C_TS_WIDTH)-1:0] Rd_Data,
  output logic [1:0]                Sts_State,
  output logic [C_DEPTH_LOG2-1:0]   Sts_Wr_Ptr,
  output logic [C_DEPTH_LOG2-1:0]   Sts_Trig_Ptr,
  output logic                      Sts_Wrapped,
  output logic [15:0]               Sts_Lost
);

  localparam int C_REC_WIDTH = rec_w(C_DATA_WIDTH, C_TS_WIDTH);
  localparam int BE_W        = C_DATA_WIDTH / 8;

  state_t                    r_state, w_state_nxt;
  logic [C_DEPTH_LOG2-1:0]   r_wr_ptr, r_trig_ptr, r_post_cnt, w_post_nxt;
  logic                      r_wrapped;
  logic [15:0]               r_lost;
  logic                      w_evt_a, w_evt_w, w_evt_r, w_any, w_capture, w_rec;
  logic                      w_hit, w_trig;
  logic [1:0]                w_nevt, w_extra;
  logic [16:0]               w_lost_sum;
  logic [1:0]                w_evt_code;
  logic [7:0]                w_info;
  logic [C_DATA_WIDTH-1:0]   w_payload;
  logic [C_REC_WIDTH-1:0]    w_rec_data;

  assign w_evt_a   = PIM_AddrReq & PIM_AddrAck;
  assign w_evt_w   = PIM_WrFIFO_Push;
  assign w_evt_r   = PIM_RdFIFO_Pop;
  assign w_any     = w_evt_a | w_evt_w | w_evt_r;
  assign w_nevt    = {1'b0, w_evt_a} + {1'b0, w_evt_w} + {1'b0, w_evt_r};
  assign w_extra   = w_any ? (w_nevt - 2'd1) : 2'd0;
  assign w_lost_sum = {1'b0, r_lost} + {15'd0, w_extra};

  // An arm pulse restarts the capture, so nothing is recorded in that cycle.
  assign w_capture = ((r_state == ST_ARMED) || (r_state == ST_POST)) && !Cfg_Arm;
  assign w_rec     = w_capture && w_any;

  always_comb begin
    w_evt_code = EVT_RD;
    w_info     = '0;
    w_payload  = PIM_RdFIFO_Data;
    if (w_evt_a) begin
      w_evt_code     = EVT_ADDR;
      w_info         = {PIM_RNW, 3'b000, PIM_Size};
      w_payload      = '0;
      w_payload[31:0] = PIM_Addr;
    end else if (w_evt_w) begin
      w_evt_code          = EVT_WR;
      w_info[BE_W-1:0]    = PIM_WrFIFO_BE;
      w_payload           = PIM_WrFIFO_Data;
    end
  end

  assign w_hit  = (((PIM_Addr ^ Cfg_Addr_Match) & Cfg_Addr_Mask) == 32'd0) &&
                  (!Cfg_Rnw_Care || (PIM_RNW == Cfg_Rnw_Val));
  assign w_trig = (r_state == ST_ARMED) && !Cfg_Arm &&
                  (Cfg_Force_Trig || (w_evt_a && w_hit));

  // Post count field is only C_DEPTH_LOG2 wide, so it can never exceed depth-1.
  always_comb begin
    w_state_nxt = r_state;
    w_post_nxt  = r_post_cnt;
    if (Cfg_Arm) begin
      w_state_nxt = ST_ARMED;
    end else begin
      case (r_state)
        ST_ARMED: begin
          if (w_trig) begin
            w_post_nxt  = Cfg_Post_Cnt;
            w_state_nxt = (Cfg_Post_Cnt == '0) ? ST_DONE : ST_POST;
          end
        end
        ST_POST: begin
          if (w_rec) begin
            w_post_nxt = r_post_cnt - 1'b1;
            if (r_post_cnt == {{(C_DEPTH_LOG2-1){1'b0}}, 1'b1}) w_state_nxt = ST_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_post_cnt <= '0;
      r_wr_ptr   <= '0;
      r_trig_ptr <= '0;
      r_wrapped  <= 1'b0;
      r_lost     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_post_cnt <= w_post_nxt;
      if (Cfg_Arm) begin
        r_wr_ptr   <= '0;
        r_trig_ptr <= '0;
        r_wrapped  <= 1'b0;
        r_lost     <= '0;
      end else begin
        if (w_trig) r_trig_ptr <= r_wr_ptr;
        if (w_rec) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          if (r_wr_ptr == '1) r_wrapped <= 1'b1;
          r_lost   <= w_lost_sum[16] ? 16'hFFFF : w_lost_sum[15:0];
        end
      end
    end
  end

`ifdef PIM_TRACE_TS_EN
  logic [ts_w(C_TS_WIDTH)-1:0] r_ts;

  always_ff @(posedge clk) begin
    if (rst)            r_ts <= '0;
    else if (Cfg_Arm)   r_ts <= '0;
    else if (w_capture) r_ts <= r_ts + 1'b1;
  end

  assign w_rec_data = {r_ts, w_evt_code, w_info, w_payload};
`else
  assign w_rec_data = {w_evt_code, w_info, w_payload};
`endif

  pim_trace_ram #(
    .WIDTH  (C_REC_WIDTH),
    .ADDR_W (C_DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_rec),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_rec_data),
    .i_re    (Rd_En),
    .i_raddr (Rd_Addr),
    .o_rdata (Rd_Data)
  );

  assign Sts_State    = r_state;
  assign Sts_Wr_Ptr   = r_wr_ptr;
  assign Sts_Trig_Ptr = r_trig_ptr;
  assign Sts_Wrapped  = r_wrapped;
  assign Sts_Lost     = r_lost;

endmodule

`default_nettype wire

// File: tb/tb_pim_trace.sv
// ============================================================================
// tb_pim_trace : directed bench with a cycle-level behavioural trace model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pim_trace;
  import pim_trace_pkg::*;

  localparam int DW    = 32;
  localparam int N     = 4;
  localparam int DEPTH = 16;
  localparam int TSW   = 16;
  localparam int REC_W = rec_w(DW, TSW);
  localparam int TSE   = ts_w(TSW);
  localparam int EL    = evt_lsb(DW);

  logic              clk, rst;
  logic [31:0]       PIM_Addr;
  logic              PIM_AddrReq, PIM_AddrAck, PIM_RNW;
  logic [3:0]        PIM_Size;
  logic [DW-1:0]     PIM_WrFIFO_Data, PIM_RdFIFO_Data;
  logic [DW/8-1:0]   PIM_WrFIFO_BE;
  logic              PIM_WrFIFO_Push, PIM_RdFIFO_Pop;
  logic              Cfg_Arm, Cfg_Force_Trig, Cfg_Rnw_Care, Cfg_Rnw_Val;
  logic [31:0]       Cfg_Addr_Match, Cfg_Addr_Mask;
  logic [N-1:0]      Cfg_Post_Cnt, Rd_Addr;
  logic              Rd_En;
  logic [REC_W-1:0]  Rd_Data;
  logic [1:0]        Sts_State;
  logic [N-1:0]      Sts_Wr_Ptr, Sts_Trig_Ptr;
  logic              Sts_Wrapped;
  logic [15:0]       Sts_Lost;

  pim_trace #(.C_DATA_WIDTH(DW), .C_DEPTH_LOG2(N), .C_TS_WIDTH(TSW)) dut (
    .clk(clk), .rst(rst),
    .PIM_Addr(PIM_Addr), .PIM_AddrReq(PIM_AddrReq), .PIM_AddrAck(PIM_AddrAck),
    .PIM_RNW(PIM_RNW), .PIM_Size(PIM_Size),
    .PIM_WrFIFO_Data(PIM_WrFIFO_Data), .PIM_WrFIFO_BE(PIM_WrFIFO_BE),
    .PIM_WrFIFO_Push(PIM_WrFIFO_Push), .PIM_RdFIFO_Data(PIM_RdFIFO_Data),
    .PIM_RdFIFO_Pop(PIM_RdFIFO_Pop), .Cfg_Arm(Cfg_Arm), .Cfg_Force_Trig(Cfg_Force_Trig),
    .Cfg_Addr_Match(Cfg_Addr_Match), .Cfg_Addr_Mask(Cfg_Addr_Mask),
    .Cfg_Rnw_Care(Cfg_Rnw_Care), .Cfg_Rnw_Val(Cfg_Rnw_Val), .Cfg_Post_Cnt(Cfg_Post_Cnt),
    .Rd_En(Rd_En), .Rd_Addr(Rd_Addr), .Rd_Data(Rd_Data),
    .Sts_State(Sts_State), .Sts_Wr_Ptr(Sts_Wr_Ptr), .Sts_Trig_Ptr(Sts_Trig_Ptr),
    .Sts_Wrapped(Sts_Wrapped), .Sts_Lost(Sts_Lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_state, m_wr, m_trig, m_post, m_lost, m_ts;
  bit          m_wrap, m_rdv, started;
  logic [63:0] m_mem [DEPTH];
  bit          m_memv [DEPTH];
  logic [63:0] m_rd;

  function automatic logic [63:0] make_rec(input int ts);
    logic [63:0] evt, info, pay, r;
    if (PIM_AddrReq && PIM_AddrAck) begin
      evt = 1; info = {56'd0, PIM_RNW, 3'b000, PIM_Size}; pay = {32'd0, PIM_Addr};
    end else if (PIM_WrFIFO_Push) begin
      evt = 2; info = {60'd0, PIM_WrFIFO_BE}; pay = {32'd0, PIM_WrFIFO_Data};
    end else begin
      evt = 3; info = 0; pay = {32'd0, PIM_RdFIFO_Data};
    end
    r = (evt << (DW + 8)) | (info << DW) | pay;
    if (TSE > 0) r = r | (64'(ts) << (DW + 10));
    return r;
  endfunction

  always @(posedge clk) begin : p_model
    int na;
    bit ev_a, hit, trig;
    if (rst) begin
      m_state = 0; m_wr = 0; m_trig = 0; m_post = 0; m_lost = 0; m_ts = 0;
      m_wrap = 0; m_rd = 0; m_rdv = 1; started = 1;
      for (int i = 0; i < DEPTH; i++) m_memv[i] = 0;
    end else begin
      if (Rd_En) begin
        m_rdv = m_memv[Rd_Addr];
        m_rd  = m_mem[Rd_Addr];
      end
      ev_a = PIM_AddrReq && PIM_AddrAck;
      na = int'(ev_a) + int'(PIM_WrFIFO_Push) + int'(PIM_RdFIFO_Pop);
      if (Cfg_Arm) begin
        m_state = 1; m_wr = 0; m_trig = 0; m_wrap = 0; m_lost = 0; m_ts = 0;
      end else if (m_state == 1 || m_state == 2) begin
        if (na > 0) begin
          m_mem[m_wr]  = make_rec(m_ts);
          m_memv[m_wr] = 1;
          m_lost = (m_lost + na - 1 > 65535) ? 65535 : m_lost + na - 1;
        end
        hit  = (((PIM_Addr ^ Cfg_Addr_Match) & Cfg_Addr_Mask) == 0) &&
               (!Cfg_Rnw_Care || PIM_RNW == Cfg_Rnw_Val);
        trig = (m_state == 1) && (Cfg_Force_Trig || (ev_a && hit));
        if (trig) begin
          m_trig = m_wr;
          if (Cfg_Post_Cnt == 0) m_state = 3;
          else begin m_state = 2; m_post = int'(Cfg_Post_Cnt); end
        end else if (m_state == 2 && na > 0) begin
          m_post--;
          if (m_post == 0) m_state = 3;
        end
        if (na > 0) begin
          m_wr = (m_wr + 1) % DEPTH;
          if (m_wr == 0) m_wrap = 1;
        end
        m_ts = (m_ts + 1) % (1 << TSW);
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (started) begin
      chk("state",    64'(Sts_State),    64'(m_state));
      chk("wr_ptr",   64'(Sts_Wr_Ptr),   64'(m_wr));
      chk("trig_ptr", 64'(Sts_Trig_Ptr), 64'(m_trig));
      chk("wrapped",  64'(Sts_Wrapped),  64'(m_wrap));
      chk("lost",     64'(Sts_Lost),     64'(m_lost));
      if (m_rdv) chk("rd_data", 64'(Rd_Data), m_rd);
    end
  end

  // ---------------- stimulus ----------------
  task automatic clr_in();
    PIM_AddrReq = 0; PIM_AddrAck = 0; PIM_WrFIFO_Push = 0; PIM_RdFIFO_Pop = 0;
    Cfg_Arm = 0; Cfg_Force_Trig = 0; Rd_En = 0;
  endtask

  task automatic arm();
    Cfg_Arm = 1; @(negedge clk); Cfg_Arm = 0;
  endtask

  task automatic ev(input bit ea, input bit ew, input bit er, input logic [31:0] addr,
                    input bit rnw, input logic [31:0] d);
    PIM_AddrReq = ea; PIM_AddrAck = ea; PIM_Addr = addr; PIM_RNW = rnw;
    PIM_WrFIFO_Push = ew; PIM_WrFIFO_Data = d;
    PIM_RdFIFO_Pop = er;  PIM_RdFIFO_Data = d ^ 32'hA5A5_0000;
    @(negedge clk);
    clr_in();
  endtask

  task automatic rd(input int addr);
    Rd_En = 1; Rd_Addr = N'(addr); @(negedge clk); Rd_En = 0;
  endtask

  initial begin
    clr_in();
    rst = 1; PIM_Addr = 0; PIM_RNW = 0; PIM_Size = 4'h3; PIM_WrFIFO_BE = 4'hF;
    PIM_WrFIFO_Data = 0; PIM_RdFIFO_Data = 0; Rd_Addr = 0;
    Cfg_Addr_Match = 32'h1000_0000; Cfg_Addr_Mask = 32'hFFFF_FF00;
    Cfg_Rnw_Care = 0; Cfg_Rnw_Val = 0; Cfg_Post_Cnt = 4'd3;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("reset_state", 64'(Sts_State), 64'd0);
    chk("reset_rd",    64'(Rd_Data),   64'd0);

    // Pre/post capture with wrap
    arm();
    for (int i = 0; i < 20; i++) ev(0, 1, 0, 32'h0, 0, 32'(i));
    ev(1, 0, 0, 32'h1000_0040, 1, 32'h0);
    for (int i = 0; i < 5; i++) ev(0, 0, 1, 32'h0, 0, 32'h100 + 32'(i));
    chk("t1_state", 64'(Sts_State), 64'd3);
    chk("t1_trig",  64'(Sts_Trig_Ptr), 64'd4);
    chk("t1_wrap",  64'(Sts_Wrapped), 64'd1);
    chk("t1_wr",    64'(Sts_Wr_Ptr), 64'd8);
    rd(4);
    chk("t1_rec4_evt", 64'(Rd_Data[EL+1:EL]), 64'd1);
    chk("t1_rec4_pay", 64'(Rd_Data[DW-1:0]), 64'h1000_0040);
    rd(7);
    chk("t1_rec7_evt", 64'(Rd_Data[EL+1:EL]), 64'd3);
    chk("t1_rec7_pay", 64'(Rd_Data[DW-1:0]), 64'hA5A5_0102);
    rd(8);
    chk("t1_rec8_pay", 64'(Rd_Data[DW-1:0]), 64'd8);

    // Mask / RNW qualification
    Cfg_Rnw_Care = 1; Cfg_Rnw_Val = 1; Cfg_Post_Cnt = 4'd2;
    arm();
    ev(1, 0, 0, 32'h1000_0040, 0, 32'h0);
    chk("t2_wr_notrig", 64'(Sts_State), 64'd1);
    PIM_AddrReq = 1; PIM_Addr = 32'h1000_0040; PIM_RNW = 1; @(negedge clk); clr_in();
    chk("t2_noack_notrig", 64'(Sts_State), 64'd1);
    ev(1, 0, 0, 32'h1000_0040, 1, 32'h0);
    chk("t2_rd_trig", 64'(Sts_State), 64'd2);
    chk("t2_trig_ptr", 64'(Sts_Trig_Ptr), 64'd1);
    rd(1);
    chk("t2_info7", 64'(Rd_Data[DW+7]), 64'd1);
    ev(0, 0, 1, 32'h0, 0, 32'h7); ev(0, 0, 1, 32'h0, 0, 32'h8);
    chk("t2_done", 64'(Sts_State), 64'd3);

    // Simultaneous events
    Cfg_Rnw_Care = 0; Cfg_Addr_Match = 32'hFFFF_0000; Cfg_Addr_Mask = 32'hFFFF_FFFF;
    arm();
    for (int i = 0; i < 3; i++) ev(1, 1, 1, 32'h20 + 32'(i), 0, 32'h55);
    chk("t3_lost", 64'(Sts_Lost), 64'd6);
    chk("t3_wr",   64'(Sts_Wr_Ptr), 64'd3);
    rd(2);
    chk("t3_rec2_evt", 64'(Rd_Data[EL+1:EL]), 64'd1);
    chk("t3_rec2_pay", 64'(Rd_Data[DW-1:0]), 64'h22);

    // Force trigger with zero post count
    Cfg_Post_Cnt = 4'd0;
    arm();
    ev(0, 1, 0, 32'h0, 0, 32'h9);
    Cfg_Force_Trig = 1; @(negedge clk); Cfg_Force_Trig = 0;
    chk("t4_done", 64'(Sts_State), 64'd3);
    chk("t4_wr",   64'(Sts_Wr_Ptr), 64'd1);
    chk("t4_trig", 64'(Sts_Trig_Ptr), 64'd1);

    // Maximum post count keeps the trigger record
    Cfg_Post_Cnt = 4'd15; Cfg_Addr_Match = 32'h1000_0000; Cfg_Addr_Mask = 32'hFFFF_FF00;
    arm();
    for (int i = 0; i < 3; i++) ev(0, 1, 0, 32'h0, 0, 32'(i));
    ev(1, 0, 0, 32'h1000_0044, 0, 32'h0);
    for (int i = 0; i < 20; i++) ev(0, 0, 1, 32'h0, 0, 32'h200 + 32'(i));
    chk("t5_state", 64'(Sts_State), 64'd3);
    chk("t5_wr",    64'(Sts_Wr_Ptr), 64'd3);
    chk("t5_trig",  64'(Sts_Trig_Ptr), 64'd3);
    rd(3);
    chk("t5_trig_pay", 64'(Rd_Data[DW-1:0]), 64'h1000_0044);
    rd(2);
    chk("t5_last_pay", 64'(Rd_Data[DW-1:0]), 64'hA5A5_020E);

    // Re-arm during POST, arm beats trigger, reset during POST
    Cfg_Post_Cnt = 4'd5;
    arm();
    ev(1, 0, 0, 32'h1000_0000, 0, 32'h0);
    ev(0, 1, 1, 32'h0, 0, 32'h3);
    chk("t6_post", 64'(Sts_State), 64'd2);
    chk("t6_lost", 64'(Sts_Lost), 64'd1);
    arm();
    chk("t6_rearm_state", 64'(Sts_State), 64'd1);
    chk("t6_rearm_wr",    64'(Sts_Wr_Ptr), 64'd0);
    chk("t6_rearm_lost",  64'(Sts_Lost), 64'd0);
    Cfg_Force_Trig = 1; arm(); Cfg_Force_Trig = 0;
    chk("t6_arm_wins", 64'(Sts_State), 64'd1);
    ev(1, 0, 0, 32'h1000_0000, 0, 32'h0);
    chk("t6_post2", 64'(Sts_State), 64'd2);
    rst = 1; @(negedge clk); rst = 0;
    chk("t6_rst_state", 64'(Sts_State), 64'd0);
    ev(0, 1, 0, 32'h0, 0, 32'h4);
    chk("t6_idle_wr", 64'(Sts_Wr_Ptr), 64'd0);

`ifdef PIM_TRACE_TS_EN
    Cfg_Post_Cnt = 4'd1;
    arm();
    repeat (3) @(negedge clk);
    ev(1, 0, 0, 32'h1000_0000, 0, 32'h0);
    rd(0);
    chk("ts_field", 64'(Rd_Data[REC_W-1:ts_lsb(DW)]), 64'd3);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
